// File: rtl/mont_mod_exp_mul_ctrl_if.sv
// Control/status and stream handshake bundle between the Montgomery exponentiation
// controller (master) and its dpath plus accelerator environment (slave).
interface mont_mod_exp_mul_ctrl_if;
   // Every val/rdy pair transfers on a rising edge where both are high; a val, once
   // raised, holds (with its payload) until that edge.
   logic        istream_val;
   logic        istream_rdy;
   logic        ostream_val;
   logic        ostream_rdy;

   logic        e_mux_sel;
   logic        r_mux_sel;
   logic        b_mux_sel;
   logic        e_reg_en;
   logic        r_reg_en;
   logic        b_reg_en;
   logic        n_reg_en;

   logic        r_mulrem_i_val;
   logic        r_mulrem_o_rdy;
   logic        b_mulrem_i_val;
   logic        b_mulrem_o_rdy;

   logic [31:0] e_reg_out;
   logic        r_mulrem_i_rdy;
   logic        r_mulrem_o_val;
   logic        b_mulrem_i_rdy;
   logic        b_mulrem_o_val;

   modport master (
      input  istream_val, ostream_rdy, e_reg_out,
      input  r_mulrem_i_rdy, r_mulrem_o_val, b_mulrem_i_rdy, b_mulrem_o_val,
      output istream_rdy, ostream_val,
      output e_mux_sel, r_mux_sel, b_mux_sel,
      output e_reg_en, r_reg_en, b_reg_en, n_reg_en,
      output r_mulrem_i_val, r_mulrem_o_rdy, b_mulrem_i_val, b_mulrem_o_rdy
   );

   modport slave (
      output istream_val, ostream_rdy, e_reg_out,
      output r_mulrem_i_rdy, r_mulrem_o_val, b_mulrem_i_rdy, b_mulrem_o_val,
      input  istream_rdy, ostream_val,
      input  e_mux_sel, r_mux_sel, b_mux_sel,
      input  e_reg_en, r_reg_en, b_reg_en, n_reg_en,
      input  r_mulrem_i_val, r_mulrem_o_rdy, b_mulrem_i_val, b_mulrem_o_rdy
   );
endinterface

// File: rtl/mont_mod_exp_mul_ctrl.sv
// Right-to-left square-and-multiply controller driving parallel r/b MulRem units.
// Optional macro RSA_XCEL_MONT_SKIP_LAST_SQUARE_EN drops the final, unused squaring.
module mont_mod_exp_mul_ctrl (
   input  logic                           clk,
   input  logic                           reset,
   mont_mod_exp_mul_ctrl_if.master        bus,
   output logic [2:0]                     o_dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CHECK = 3'd1,
      S_ISSUE = 3'd2,
      S_WAIT  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic r_need_r;
   logic r_need_b;
   logic r_r_sent;
   logic r_b_sent;
   logic w_need_r_nxt;
   logic w_need_b_nxt;
   logic w_r_sent_nxt;
   logic w_b_sent_nxt;

   logic w_istream_rdy;
   logic w_ostream_val;
   logic w_e_mux_sel;
   logic w_r_mux_sel;
   logic w_b_mux_sel;
   logic w_e_reg_en;
   logic w_r_reg_en;
   logic w_b_reg_en;
   logic w_n_reg_en;
   logic w_r_i_val;
   logic w_b_i_val;
   logic w_r_o_rdy;
   logic w_b_o_rdy;
   logic w_all_res;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_need_r <= 1'b0;
         r_need_b <= 1'b0;
         r_r_sent <= 1'b0;
         r_b_sent <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_need_r <= w_need_r_nxt;
         r_need_b <= w_need_b_nxt;
         r_r_sent <= w_r_sent_nxt;
         r_b_sent <= w_b_sent_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_need_r_nxt  = r_need_r;
      w_need_b_nxt  = r_need_b;
      w_r_sent_nxt  = r_r_sent;
      w_b_sent_nxt  = r_b_sent;
      w_istream_rdy = 1'b0;
      w_ostream_val = 1'b0;
      w_e_mux_sel   = 1'b0;
      w_r_mux_sel   = 1'b0;
      w_b_mux_sel   = 1'b0;
      w_e_reg_en    = 1'b0;
      w_r_reg_en    = 1'b0;
      w_b_reg_en    = 1'b0;
      w_n_reg_en    = 1'b0;
      w_r_i_val     = 1'b0;
      w_b_i_val     = 1'b0;
      w_r_o_rdy     = 1'b0;
      w_b_o_rdy     = 1'b0;
      w_all_res     = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_istream_rdy = 1'b1;
            if (bus.istream_val) begin
               w_e_reg_en  = 1'b1;
               w_r_reg_en  = 1'b1;
               w_b_reg_en  = 1'b1;
               w_n_reg_en  = 1'b1;
               w_state_nxt = S_CHECK;
            end
         end

         S_CHECK: begin
            if (bus.e_reg_out == 32'd0) begin
               w_state_nxt = S_DONE;
            end else begin
               w_need_r_nxt = bus.e_reg_out[0];
`ifdef RSA_XCEL_MONT_SKIP_LAST_SQUARE_EN
               // With e==1 the squared base is never consumed again.
               w_need_b_nxt = (bus.e_reg_out != 32'd1);
`else
               w_need_b_nxt = 1'b1;
`endif
               w_r_sent_nxt = 1'b0;
               w_b_sent_nxt = 1'b0;
               w_state_nxt  = S_ISSUE;
            end
         end

         S_ISSUE: begin
            w_b_i_val    = r_need_b & ~r_b_sent;
            w_r_i_val    = r_need_r & ~r_r_sent;
            w_b_sent_nxt = r_b_sent | (w_b_i_val & bus.b_mulrem_i_rdy);
            w_r_sent_nxt = r_r_sent | (w_r_i_val & bus.r_mulrem_i_rdy);
            if ((~r_need_b | w_b_sent_nxt) && (~r_need_r | w_r_sent_nxt))
               w_state_nxt = S_WAIT;
         end

         S_WAIT: begin
            // Capture only once every outstanding result is present, so the
            // operand registers feeding a slower unit never move under it.
            w_all_res = (~r_need_r | bus.r_mulrem_o_val) & (~r_need_b | bus.b_mulrem_o_val);
            if (w_all_res) begin
               w_r_o_rdy   = r_need_r;
               w_b_o_rdy   = r_need_b;
               w_r_reg_en  = r_need_r;
               w_r_mux_sel = 1'b1;
               w_b_reg_en  = r_need_b;
               w_b_mux_sel = 1'b1;
               w_e_reg_en  = 1'b1;
               w_e_mux_sel = 1'b1;
               w_state_nxt = S_CHECK;
            end
         end

         S_DONE: begin
            w_ostream_val = 1'b1;
            if (bus.ostream_rdy)
               w_state_nxt = S_IDLE;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign bus.istream_rdy    = w_istream_rdy;
   assign bus.ostream_val    = w_ostream_val;
   assign bus.e_mux_sel      = w_e_mux_sel;
   assign bus.r_mux_sel      = w_r_mux_sel;
   assign bus.b_mux_sel      = w_b_mux_sel;
   assign bus.e_reg_en       = w_e_reg_en;
   assign bus.r_reg_en       = w_r_reg_en;
   assign bus.b_reg_en       = w_b_reg_en;
   assign bus.n_reg_en       = w_n_reg_en;
   assign bus.r_mulrem_i_val = w_r_i_val;
   assign bus.b_mulrem_i_val = w_b_i_val;
   assign bus.r_mulrem_o_rdy = w_r_o_rdy;
   assign bus.b_mulrem_o_rdy = w_b_o_rdy;

   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mont_mod_exp_mul_ctrl.sv
// Bench for mont_mod_exp_mul_ctrl: behavioural dpath/MulRem environment, a reference
// exponentiation model with an expected-result queue, and a per-cycle protocol checker.
`timescale 1ns/1ps
module tb_mont_mod_exp_mul_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mont_mod_exp_mul_ctrl_if bus();
  logic [2:0] dbg_state;

  mont_mod_exp_mul_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.master),
    .o_dbg_state (dbg_state)
  );

  // ---------------- environment state ----------------
  logic        tb_ival;
  logic        tb_ordy;
  logic [31:0] in_b, in_e, in_n, in_r;
  logic [31:0] dp_e, dp_r, dp_b, dp_n;
  logic        r_busy, b_busy;
  int          r_cnt, b_cnt, r_wait, b_wait;
  logic [31:0] r_res, b_res;
  int          r_lat, b_lat, stall_len;
  int          r_sends, b_sends, done_cnt, jobs_done;
  logic        job_busy;
  logic        chk_en;
  logic        prev_r_pend, prev_b_pend, prev_o_pend;
  logic [2:0]  prev_dbg;
  logic [31:0] last_result;
  logic [31:0] exp_q[$];
  int          n_chk, n_pass;

  assign bus.istream_val    = tb_ival;
  assign bus.ostream_rdy    = tb_ordy;
  assign bus.e_reg_out      = dp_e;
  assign bus.r_mulrem_i_rdy = !r_busy && (r_wait >= stall_len);
  assign bus.b_mulrem_i_rdy = !b_busy && (b_wait >= stall_len);
  assign bus.r_mulrem_o_val = r_busy && (r_cnt == 0);
  assign bus.b_mulrem_o_val = b_busy && (b_cnt == 0);

  // ---------------- reference model ----------------
  function automatic logic [31:0] mulmod(input logic [31:0] a, input logic [31:0] b, input logic [31:0] n);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    return 32'(p % longint'(n));
  endfunction

  // r0 * b^e mod n by plain repeated multiplication.
  function automatic logic [31:0] ref_exp(input logic [31:0] b, input logic [31:0] e,
                                          input logic [31:0] n, input logic [31:0] r0);
    longint unsigned r;
    r = longint'(r0);
    for (int i = 0; i < int'(e); i++) r = (r * longint'(b)) % longint'(n);
    return 32'(r);
  endfunction

  function automatic int bit_len(input logic [31:0] e);
    int l;
    l = 0;
    for (int i = 0; i < 32; i++) if (e[i]) l = i + 1;
    return l;
  endfunction

  function automatic int exp_b_sends(input logic [31:0] e);
`ifdef RSA_XCEL_MONT_SKIP_LAST_SQUARE_EN
    return (e == 0) ? 0 : bit_len(e) - 1;
`else
    return bit_len(e);
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // ---------------- dpath + MulRem behaviour ----------------
  always @(posedge clk) begin
    if (reset) begin
      r_busy <= 1'b0; b_busy <= 1'b0;
      r_wait <= 0; b_wait <= 0; r_cnt <= 0; b_cnt <= 0;
      dp_e <= '0; dp_r <= '0; dp_b <= '0; dp_n <= 32'd1;
      job_busy <= 1'b0;
      prev_r_pend <= 1'b0; prev_b_pend <= 1'b0; prev_o_pend <= 1'b0;
      exp_q.delete();
    end else begin
      if (bus.e_reg_en) dp_e <= bus.e_mux_sel ? (dp_e >> 1) : in_e;
      if (bus.r_reg_en) dp_r <= bus.r_mux_sel ? r_res : in_r;
      if (bus.b_reg_en) dp_b <= bus.b_mux_sel ? b_res : in_b;
      if (bus.n_reg_en) dp_n <= in_n;

      if (bus.r_mulrem_i_val && bus.r_mulrem_i_rdy) begin
        r_busy <= 1'b1; r_cnt <= r_lat; r_res <= mulmod(dp_r, dp_b, dp_n);
        r_wait <= 0; r_sends <= r_sends + 1;
      end else begin
        if (bus.r_mulrem_i_val) r_wait <= r_wait + 1;
        if (r_busy && r_cnt != 0) r_cnt <= r_cnt - 1;
        if (bus.r_mulrem_o_val && bus.r_mulrem_o_rdy) r_busy <= 1'b0;
      end

      if (bus.b_mulrem_i_val && bus.b_mulrem_i_rdy) begin
        b_busy <= 1'b1; b_cnt <= b_lat; b_res <= mulmod(dp_b, dp_b, dp_n);
        b_wait <= 0; b_sends <= b_sends + 1;
      end else begin
        if (bus.b_mulrem_i_val) b_wait <= b_wait + 1;
        if (b_busy && b_cnt != 0) b_cnt <= b_cnt - 1;
        if (bus.b_mulrem_o_val && bus.b_mulrem_o_rdy) b_busy <= 1'b0;
      end

      if (bus.istream_val && bus.istream_rdy) begin
        job_busy <= 1'b1;
        exp_q.push_back(ref_exp(in_b, in_e, in_n, in_r));
        r_sends <= 0; b_sends <= 0;
      end else if (bus.ostream_val && bus.ostream_rdy) begin
        job_busy <= 1'b0;
        done_cnt <= done_cnt + 1;
      end

      prev_r_pend <= bus.r_mulrem_i_val && !bus.r_mulrem_i_rdy;
      prev_b_pend <= bus.b_mulrem_i_val && !bus.b_mulrem_i_rdy;
      prev_o_pend <= bus.ostream_val && !bus.ostream_rdy;
    end
    prev_dbg <= dbg_state;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : cmp
    logic r_fire, b_fire;
    logic [31:0] e_val;
    if (!reset && chk_en) begin
      r_fire = bus.r_mulrem_o_val & bus.r_mulrem_o_rdy;
      b_fire = bus.b_mulrem_o_val & bus.b_mulrem_o_rdy;
      chk("istream_rdy", bus.istream_rdy, !job_busy);
      if (!job_busy) begin
        chk("idle_quiet", {bus.r_mulrem_i_val, bus.b_mulrem_i_val, bus.r_mulrem_o_rdy,
                           bus.b_mulrem_o_rdy, bus.ostream_val, bus.e_mux_sel,
                           bus.r_mux_sel, bus.b_mux_sel}, 0);
        chk("idle_load_en", {bus.e_reg_en, bus.r_reg_en, bus.b_reg_en, bus.n_reg_en},
            {4{bus.istream_val}});
      end else begin
        chk("n_reg_en_busy", bus.n_reg_en, 0);
        chk("r_capture", {bus.r_reg_en, bus.r_reg_en & bus.r_mux_sel}, {2{r_fire}});
        chk("b_capture", {bus.b_reg_en, bus.b_reg_en & bus.b_mux_sel}, {2{b_fire}});
        chk("e_shift", {bus.e_reg_en, bus.e_reg_en & bus.e_mux_sel}, {2{r_fire | b_fire}});
        if (bus.r_mulrem_o_rdy || bus.b_mulrem_o_rdy)
          chk("o_rdy_joint", {(!r_busy || bus.r_mulrem_o_val) && (!b_busy || bus.b_mulrem_o_val),
                              bus.r_mulrem_o_rdy == r_busy, bus.b_mulrem_o_rdy == b_busy}, 3'b111);
        chk("ival_while_busy", {bus.r_mulrem_i_val & r_busy, bus.b_mulrem_i_val & b_busy}, 0);
      end
      if (prev_r_pend) chk("r_ival_hold", bus.r_mulrem_i_val, 1);
      if (prev_b_pend) chk("b_ival_hold", bus.b_mulrem_i_val, 1);
      if (prev_o_pend) chk("ostream_hold", {bus.ostream_val, dbg_state == prev_dbg}, 2'b11);
      if (bus.ostream_val && bus.ostream_rdy) begin
        if (exp_q.size() == 0) begin
          chk("result_unexpected", bus.ostream_val, 0);
        end else begin
          e_val = exp_q.pop_front();
          chk("result", dp_r, e_val);
          last_result = dp_r;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input logic [31:0] b, input logic [31:0] e, input logic [31:0] n,
                         input logic [31:0] r0, input int rl, input int bl, input int st,
                         input int dd, input logic spam, output int lat);
    int guard;
    r_lat = rl; b_lat = bl; stall_len = st;
    in_b = b; in_e = e; in_n = n; in_r = r0;
    tb_ival = 1'b1;
    guard = 0;
    while (!bus.istream_rdy && guard < 100) begin step(); guard++; end
    chk("istream_timeout", bus.istream_rdy, 1);
    step();
    tb_ival = spam;
    lat = 1;
    while (!bus.ostream_val && lat < 3000) begin step(); lat++; end
    chk("ostream_timeout", bus.ostream_val, 1);
    repeat (dd) step();
    tb_ordy = 1'b1;
    step();
    tb_ordy = 1'b0;
    tb_ival = 1'b0;
    jobs_done++;
    chk("r_sends", r_sends, $countones(e));
    chk("b_sends", b_sends, exp_b_sends(e));
    if (e == 0) chk("e0_latency", lat, 2);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat, guard, kind;
    logic [31:0] rb, re, rn, rr;
    n_chk = 0; n_pass = 0; jobs_done = 0; done_cnt = 0;
    r_sends = 0; b_sends = 0; last_result = '0;
    reset = 1'b1; tb_ival = 1'b0; tb_ordy = 1'b0; chk_en = 1'b0;
    in_b = '0; in_e = '0; in_n = 32'd1; in_r = '0;
    r_lat = 0; b_lat = 0; stall_len = 0;
    repeat (3) step();
    reset = 1'b0;
    chk_en = 1'b1;
    step();
    chk("rst_istream_rdy", bus.istream_rdy, 1);
    chk("rst_outputs", {bus.ostream_val, bus.e_mux_sel, bus.r_mux_sel, bus.b_mux_sel,
                        bus.e_reg_en, bus.r_reg_en, bus.b_reg_en, bus.n_reg_en,
                        bus.r_mulrem_i_val, bus.r_mulrem_o_rdy,
                        bus.b_mulrem_i_val, bus.b_mulrem_o_rdy}, 0);

    // Model pins: classic textbook values.
    chk("model_pin_445", ref_exp(32'd4, 32'd13, 32'd497, 32'd1), 445);
    chk("model_pin_e0", ref_exp(32'd9, 32'd0, 32'd497, 32'd7), 7);

    run_job(32'd4, 32'd13, 32'd497, 32'd1, 1, 1, 0, 0, 1'b0, lat);
    chk("job_445", last_result, 445);
    run_job(32'd5, 32'd0, 32'd497, 32'd7, 1, 1, 0, 0, 1'b0, lat);
    chk("job_e0_result", last_result, 7);
    run_job(32'd3, 32'd2, 32'd101, 32'd1, 0, 5, 0, 0, 1'b0, lat);
    chk("job_e2_result", last_result, 9);
    run_job(32'd3, 32'd3, 32'd101, 32'd1, 0, 6, 0, 0, 1'b0, lat);
    chk("job_e3_result", last_result, 27);
    run_job(32'd4, 32'd13, 32'd497, 32'd1, 2, 3, 4, 0, 1'b0, lat);
    chk("job_stall_result", last_result, 445);
    run_job(32'd4, 32'd13, 32'd497, 32'd1, 0, 0, 0, 10, 1'b1, lat);
    chk("job_done_hold_result", last_result, 445);

    // Abort a job in WAIT during its second iteration.
    r_lat = 8; b_lat = 8; stall_len = 0;
    in_b = 32'd4; in_e = 32'd13; in_n = 32'd497; in_r = 32'd1;
    tb_ival = 1'b1;
    guard = 0;
    while (!bus.istream_rdy && guard < 100) begin step(); guard++; end
    step();
    tb_ival = 1'b0;
    guard = 0;
    while (b_sends < 2 && guard < 200) begin step(); guard++; end
    chk("abort_reach_iter2", b_sends, 2);
    step(); step();
    reset = 1'b1;
    step();
    chk("abort_istream_rdy", bus.istream_rdy, 1);
    chk("abort_outputs", {bus.ostream_val, bus.e_mux_sel, bus.r_mux_sel, bus.b_mux_sel,
                          bus.e_reg_en, bus.r_reg_en, bus.b_reg_en, bus.n_reg_en,
                          bus.r_mulrem_i_val, bus.r_mulrem_o_rdy,
                          bus.b_mulrem_i_val, bus.b_mulrem_o_rdy}, 0);
    reset = 1'b0;
    step();
    run_job(32'd4, 32'd13, 32'd497, 32'd1, 1, 2, 1, 1, 1'b0, lat);
    chk("job_after_abort", last_result, 445);

    for (int j = 0; j < 25; j++) begin
      kind = $urandom_range(0, 5);
      rn = $urandom_range(3, 65535) | 32'd1;
      rb = $urandom % rn;
      rr = $urandom % rn;
      if (kind == 0) re = 32'd0;
      else if (kind == 1) re = 32'd1;
      else re = $urandom_range(2, 4095);
      run_job(rb, re, rn, rr, $urandom_range(0, 6), $urandom_range(0, 6),
              $urandom_range(0, 3), $urandom_range(0, 3), 1'(($urandom_range(0, 1))), lat);
    end

    step();
    chk("done_count", done_cnt, jobs_done);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
